// File: rtl/sr_ctrl_pkg.sv
// rtl/sr_ctrl_pkg.sv - shared types and constants for the set/reset latch controller
package sr_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2,
        CHECK = 2'd3
    } state_t;

    localparam logic OP_SET = 1'b1;
    localparam logic OP_RST = 1'b0;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin grant with registered last grant
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       upd,
    output logic [1:0] gnt
);

    logic r_last_gnt;

    // Contention goes to the requester that did not win last time
    always_comb begin
        if (req == 2'b11) begin
            gnt = r_last_gnt ? 2'b01 : 2'b10;
        end else begin
            gnt = req;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_gnt <= 1'b1;
        end else if (upd) begin
            r_last_gnt <= gnt[1];
        end
    end

endmodule

// File: rtl/sr_latch_ctrl.sv
// rtl/sr_latch_ctrl.sv - arbitrated S/R pulse sequencer with shadow state
// Optional readback check enabled by SR_LATCH_CTRL_VERIFY_EN.
module sr_latch_ctrl
    import sr_ctrl_pkg::*;
#(
    parameter int PULSE_W = 4,
    parameter int GAP_W   = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_valid,
    input  logic [1:0] req_op,
    output logic [1:0] req_ready,
    output logic       S,
    output logic       R,
    input  logic       Q1,
    input  logic       Q2,
    output logic       busy,
    output logic       state_q,
    output logic       err
);

    localparam int CNT_W = $clog2(max2(PULSE_W, GAP_W) + 1);

    generate
        if (PULSE_W < 1) begin : g_bad_pulse_w
            $error("PULSE_W must be at least 1");
        end
        if (GAP_W < 1) begin : g_bad_gap_w
            $error("GAP_W must be at least 1");
        end
    endgenerate

    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_op;
    logic               r_state_q;
    logic [1:0]         w_gnt;
    logic               w_accept;
    logic               w_cnt_done;

    assign w_accept   = (r_state == IDLE) && !rst && (|req_valid);
    assign w_cnt_done = (r_cnt == '0);

    rr_arb2 u_arb (
        .clk (clk),
        .rst (rst),
        .req (req_valid),
        .upd (w_accept),
        .gnt (w_gnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:  if (w_accept) w_next = PULSE;
            PULSE: if (w_cnt_done) w_next = GAP;
`ifdef SR_LATCH_CTRL_VERIFY_EN
            GAP:   if (w_cnt_done) w_next = CHECK;
`else
            GAP:   if (w_cnt_done) w_next = IDLE;
`endif
            CHECK: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // S and R come only from the registered state, so they can never overlap
    always_comb begin
        req_ready = 2'b00;
        S         = 1'b0;
        R         = 1'b0;
        busy      = 1'b1;
        case (r_state)
            IDLE: begin
                busy      = 1'b0;
                req_ready = rst ? 2'b00 : w_gnt;
            end
            PULSE: begin
                S = (r_op == OP_SET);
                R = (r_op == OP_RST);
            end
            default: ;
        endcase
    end

    // Counter is reloaded on every state change and counts down to zero
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_next != r_state) begin
            case (w_next)
                PULSE:   r_cnt <= CNT_W'(PULSE_W - 1);
                GAP:     r_cnt <= CNT_W'(GAP_W - 1);
                default: r_cnt <= '0;
            endcase
        end else if (!w_cnt_done) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_op      <= OP_RST;
            r_state_q <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op <= w_gnt[1] ? req_op[1] : req_op[0];
            end
            if ((r_state == PULSE) && w_cnt_done) begin
                r_state_q <= r_op;
            end
        end
    end

    assign state_q = r_state_q;

`ifdef SR_LATCH_CTRL_VERIFY_EN
    logic r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if ((r_state == CHECK) && ((Q1 != r_op) || (Q2 != ~r_op))) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`else
    logic w_unused_fb;
    assign w_unused_fb = Q1 ^ Q2;
    assign err         = 1'b0;
`endif

endmodule

// File: tb/tb_sr_latch_ctrl.sv
// tb/tb_sr_latch_ctrl.sv - self-checking bench for sr_latch_ctrl
module tb_sr_latch_ctrl;

    localparam int PW = 4;
    localparam int GW = 2;
`ifdef SR_LATCH_CTRL_VERIFY_EN
    localparam int VER = 1;
`else
    localparam int VER = 0;
`endif
    localparam int L = PW + GW + VER;

    logic       clk;
    logic       rst;
    logic [1:0] req_valid;
    logic [1:0] req_op;
    logic [1:0] req_ready;
    logic       S, R, Q1, Q2, busy, state_q, err;

    int n_checks = 0;
    int n_errors = 0;

    sr_latch_ctrl #(.PULSE_W(PW), .GAP_W(GW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_op    (req_op),
        .req_ready (req_ready),
        .S         (S),
        .R         (R),
        .Q1        (Q1),
        .Q2        (Q2),
        .busy      (busy),
        .state_q   (state_q),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Transaction-level reference: phase counted from the accept cycle
    bit   m_active = 0;
    int   m_k      = 0;
    int   m_last   = 1;
    bit   m_op     = 0;
    bit   m_q      = 0;
    bit   m_err    = 0;
    bit   m_latch  = 0;
    bit   force_q1_low = 0;

    logic [1:0] exp_ready, obs_ready;
    logic       exp_s, exp_r, exp_busy, exp_q, exp_err;
    logic       obs_s, obs_r, obs_busy, obs_q, obs_err;
    int         cyc = 0;

    task automatic tick(input logic r, input logic [1:0] v, input logic [1:0] o);
        int win;
        rst       = r;
        req_valid = v;
        req_op    = o;
        Q1        = force_q1_low ? 1'b0 : m_latch;
        Q2        = ~m_latch;
        if (v == 2'b11) win = 1 - m_last;
        else            win = v[0] ? 0 : 1;
        exp_ready = (!m_active && v != 2'b00 && !r) ? (2'b01 << win) : 2'b00;
        exp_busy  = m_active;
        exp_s     = m_active && (m_k <= PW) && m_op;
        exp_r     = m_active && (m_k <= PW) && !m_op;
        exp_q     = m_q;
        exp_err   = m_err;
        @(negedge clk);
        obs_ready = req_ready;
        obs_s     = S;
        obs_r     = R;
        obs_busy  = busy;
        obs_q     = state_q;
        obs_err   = err;
        @(posedge clk);
        cyc++;
        if (exp_s) m_latch = 1;
        else if (exp_r) m_latch = 0;
        if (r) begin
            m_active = 0; m_k = 0; m_last = 1; m_op = 0; m_q = 0; m_err = 0;
        end else if (!m_active) begin
            if (v != 2'b00) begin
                m_active = 1; m_k = 1; m_last = win; m_op = o[win];
            end
        end else begin
            if (m_k == PW) m_q = m_op;
            if (VER == 1 && m_k == L && (Q1 != m_op || Q2 != !m_op)) m_err = 1;
            if (m_k == L) m_active = 0;
            else m_k++;
        end
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 30 && m_active; i++) tick(0, 2'b00, 2'b00);
    endtask

    task automatic test_reset();
        tick(1, 2'b11, 2'b11);
        tick(1, 2'b11, 2'b11);
        n_checks++;
        if ({obs_ready, obs_s, obs_r, obs_busy, obs_q, obs_err} !== 7'b0) begin
            n_errors++;
            $display("FAIL reset: ready=%b S=%b R=%b busy=%b q=%b err=%b, expected all 0",
                     obs_ready, obs_s, obs_r, obs_busy, obs_q, obs_err);
        end
        tick(0, 2'b00, 2'b00);
        n_checks++;
        if ({obs_ready, obs_s, obs_r, obs_busy} !== 5'b0) begin
            n_errors++;
            $display("FAIL idle_after_reset: ready=%b S=%b R=%b busy=%b, expected 0",
                     obs_ready, obs_s, obs_r, obs_busy);
        end
    endtask

    task automatic test_single_set();
        tick(0, 2'b01, 2'b01);
        n_checks++;
        if (obs_ready !== 2'b01) begin
            n_errors++;
            $display("FAIL set_ready: got %b expected 01", obs_ready);
        end
        for (int k = 1; k <= PW + GW; k++) begin
            tick(0, 2'b00, 2'b00);
            n_checks++;
            if (obs_s !== (k <= PW) || obs_r !== 1'b0 || obs_busy !== 1'b1 ||
                obs_q !== (k > PW)) begin
                n_errors++;
                $display("FAIL set_phase t+%0d: S=%b R=%b busy=%b q=%b, expected S=%b R=0 busy=1 q=%b",
                         k, obs_s, obs_r, obs_busy, obs_q, k <= PW, k > PW);
            end
        end
        drain();
    endtask

    task automatic test_contention();
        int t;
        tick(1, 2'b00, 2'b00);
        tick(0, 2'b11, 2'b01);
        n_checks++;
        if (obs_ready !== 2'b01) begin
            n_errors++;
            $display("FAIL contention_first: got %b expected 01", obs_ready);
        end
        t = 0;
        do begin
            tick(0, 2'b11, 2'b01);
            t++;
        end while (obs_ready == 2'b00 && t < 20);
        n_checks++;
        if (obs_ready !== 2'b10 || obs_q !== 1'b1) begin
            n_errors++;
            $display("FAIL contention_second: ready=%b q=%b, expected ready=10 q=1", obs_ready, obs_q);
        end
        drain();
        tick(0, 2'b00, 2'b00);
        n_checks++;
        if (obs_q !== 1'b0) begin
            n_errors++;
            $display("FAIL contention_final_q: got %b expected 0", obs_q);
        end
    endtask

    task automatic test_back_to_back();
        int  grants[$];
        bit  sr_both = 0;
        tick(1, 2'b00, 2'b00);
        for (int i = 0; i < 6 * (L + 1) + 10 && grants.size() < 6; i++) begin
            tick(0, 2'b11, 2'($urandom));
            if (obs_s === 1'b1 && obs_r === 1'b1) sr_both = 1;
            if (obs_ready == 2'b01) grants.push_back(0);
            if (obs_ready == 2'b10) grants.push_back(1);
        end
        n_checks++;
        if (grants.size() != 6) begin
            n_errors++;
            $display("FAIL b2b_count: got %0d grants expected 6", grants.size());
        end
        for (int i = 0; i < grants.size(); i++) begin
            n_checks++;
            if (grants[i] != i % 2) begin
                n_errors++;
                $display("FAIL b2b_order[%0d]: got %0d expected %0d", i, grants[i], i % 2);
            end
        end
        n_checks++;
        if (sr_both) begin
            n_errors++;
            $display("FAIL b2b_sr_overlap: S and R both 1, expected never");
        end
        drain();
    endtask

    task automatic test_rst_mid();
        tick(0, 2'b01, 2'b01);
        tick(0, 2'b00, 2'b00);
        tick(1, 2'b00, 2'b00);
        tick(0, 2'b00, 2'b00);
        n_checks++;
        if (obs_s !== 1'b0 || obs_busy !== 1'b0 || obs_q !== 1'b0 || obs_ready !== 2'b00) begin
            n_errors++;
            $display("FAIL rst_mid: S=%b busy=%b q=%b ready=%b, expected 0 0 0 00",
                     obs_s, obs_busy, obs_q, obs_ready);
        end
        tick(0, 2'b10, 2'b10);
        n_checks++;
        if (obs_ready !== 2'b10) begin
            n_errors++;
            $display("FAIL rst_mid_next: ready=%b expected 10", obs_ready);
        end
        drain();
    endtask

`ifdef SR_LATCH_CTRL_VERIFY_EN
    task automatic test_verify();
        tick(1, 2'b00, 2'b00);
        force_q1_low = 1;
        tick(0, 2'b01, 2'b01);
        drain();
        force_q1_low = 0;
        tick(0, 2'b00, 2'b00);
        n_checks++;
        if (obs_err !== 1'b1) begin
            n_errors++;
            $display("FAIL verify_err_set: got %b expected 1", obs_err);
        end
        tick(0, 2'b10, 2'b00);
        drain();
        tick(0, 2'b00, 2'b00);
        n_checks++;
        if (obs_err !== 1'b1) begin
            n_errors++;
            $display("FAIL verify_err_sticky: got %b expected 1", obs_err);
        end
        tick(1, 2'b00, 2'b00);
        tick(0, 2'b00, 2'b00);
        n_checks++;
        if (obs_err !== 1'b0) begin
            n_errors++;
            $display("FAIL verify_err_clear: got %b expected 0", obs_err);
        end
    endtask
`else
    task automatic test_spacing();
        int t_acc[$];
        tick(1, 2'b00, 2'b00);
        for (int i = 0; i < 30 && t_acc.size() < 3; i++) begin
            tick(0, 2'b01, 2'b00);
            if (obs_ready == 2'b01) t_acc.push_back(cyc);
        end
        n_checks++;
        if (t_acc.size() != 3) begin
            n_errors++;
            $display("FAIL spacing_count: got %0d accepts expected 3", t_acc.size());
        end else begin
            for (int i = 1; i < 3; i++) begin
                n_checks++;
                if (t_acc[i] - t_acc[i-1] != PW + GW + 1) begin
                    n_errors++;
                    $display("FAIL spacing[%0d]: got %0d expected %0d",
                             i, t_acc[i] - t_acc[i-1], PW + GW + 1);
                end
            end
        end
        n_checks++;
        if (obs_err !== 1'b0) begin
            n_errors++;
            $display("FAIL spacing_err: got %b expected 0", obs_err);
        end
        drain();
    endtask
`endif

    task automatic test_random();
        int bad = 0;
        for (int i = 0; i < 600; i++) begin
            tick(($urandom_range(0, 60) == 0), 2'($urandom), 2'($urandom));
            n_checks++;
            if ({obs_ready, obs_s, obs_r, obs_busy, obs_q, obs_err} !==
                {exp_ready, exp_s, exp_r, exp_busy, exp_q, exp_err} ||
                (obs_s === 1'b1 && obs_r === 1'b1)) begin
                n_errors++;
                if (bad++ < 10)
                    $display("FAIL random cyc %0d: ready=%b S=%b R=%b busy=%b q=%b err=%b, expected %b %b %b %b %b %b",
                             cyc, obs_ready, obs_s, obs_r, obs_busy, obs_q, obs_err,
                             exp_ready, exp_s, exp_r, exp_busy, exp_q, exp_err);
            end
        end
    endtask

    initial begin
        rst = 1'b1; req_valid = 2'b00; req_op = 2'b00; Q1 = 1'b0; Q2 = 1'b1;
        test_reset();
        test_single_set();
        test_contention();
        test_back_to_back();
        test_rst_mid();
`ifdef SR_LATCH_CTRL_VERIFY_EN
        test_verify();
`else
        test_spacing();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
